// File: rtl/if_stage_pkg.sv
// ==== if_stage_pkg : shared fetch-stage encodings and ISA constants ====
// ==== rev 1.0                                                        ====
`default_nettype none

package if_stage_pkg;

  localparam logic [31:0] ISA_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_STATE_IDLE   = 2'd0,
    IF_STATE_ACCESS = 2'd1,
    IF_STATE_READY  = 2'd2
  } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_reg.sv
// ==== if_reg : IF/ID pipeline register and program counter update ====
// ==== rev 1.0                                                      ====
`default_nettype none

module if_reg
  import if_stage_pkg::*;
#(
  parameter int              ADDR_W       = 30,
  parameter int              DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_consume,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_new_pc,
  input  logic              i_br_taken,
  input  logic [ADDR_W-1:0] i_br_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [DATA_W-1:0] o_if_insn,
  output logic              o_if_en
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_pc      <= RESET_VECTOR;
      o_if_pc   <= '0;
      o_if_insn <= DATA_W'(ISA_NOP);
      o_if_en   <= 1'b0;
    end else if (i_consume) begin
      o_if_pc <= o_pc;
      if (i_flush) begin
        o_pc      <= i_new_pc;
        o_if_insn <= DATA_W'(ISA_NOP);
        o_if_en   <= 1'b0;
      end else begin
        // The fetched word still enters ID on a taken branch: it is the delay slot.
        o_pc      <= i_br_taken ? i_br_addr : o_pc + ADDR_W'(1);
        o_if_insn <= i_data;
        o_if_en   <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ==== if_stage : instruction fetch FSM, bus master and instruction buffer ====
// ==== rev 1.0                                                            ====
`default_nettype none

module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W       = 30,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_stall,
  input  logic              if_flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_as,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy,
  output logic              if_busy,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);

  if_state_e         r_state;
  logic [DATA_W-1:0] r_insn_buf;
  logic [ADDR_W-1:0] w_pc;
  logic              w_access;
  logic              w_ready;
  logic              w_consume;
  logic [DATA_W-1:0] w_data;

  assign w_access  = (r_state == IF_STATE_ACCESS);
  assign w_ready   = (r_state == IF_STATE_READY);
  assign w_consume = ~if_stall & ((w_access & bus_rdy) | w_ready);
  assign w_data    = w_ready ? r_insn_buf : bus_rd_data;

  // Bus outputs never look at if_stall, which itself folds in if_busy.
  assign bus_req  = ~reset;
  assign bus_as   = w_access;
  assign bus_addr = w_pc;
  assign if_busy  = (r_state == IF_STATE_IDLE) | (w_access & ~bus_rdy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IF_STATE_IDLE;
      r_insn_buf <= '0;
    end else begin
      case (r_state)
        IF_STATE_IDLE: begin
          if (bus_grant) r_state <= IF_STATE_ACCESS;
        end
        IF_STATE_ACCESS: begin
          if (bus_rdy) begin
            if (if_stall) begin
              r_insn_buf <= bus_rd_data;
              r_state    <= IF_STATE_READY;
            end
          end else if (!bus_grant) begin
            r_state <= IF_STATE_IDLE;
          end
        end
        IF_STATE_READY: begin
          if (!if_stall) r_state <= bus_grant ? IF_STATE_ACCESS : IF_STATE_IDLE;
        end
        default: r_state <= IF_STATE_IDLE;
      endcase
    end
  end

  if_reg #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_if_reg (
    .clk        (clk),
    .reset      (reset),
    .i_consume  (w_consume),
    .i_flush    (if_flush),
    .i_new_pc   (new_pc),
    .i_br_taken (br_taken),
    .i_br_addr  (br_addr),
    .i_data     (w_data),
    .o_pc       (w_pc),
    .o_if_pc    (if_pc),
    .o_if_insn  (if_insn),
    .o_if_en    (if_en)
  );

endmodule

`default_nettype wire
